// File: rtl/store_buffer_pkg.sv
// Shared size encodings and lane-formatting helpers for the store buffer.
package store_buffer_pkg;

    localparam int unsigned STB_DEPTH    = 4;
    localparam int unsigned MEM_SZ_WIDTH = 2;

    typedef enum logic [MEM_SZ_WIDTH-1:0] {
        MEM_SZ_B = 2'd0,
        MEM_SZ_H = 2'd1,
        MEM_SZ_W = 2'd2,
        MEM_SZ_D = 2'd3
    } mem_sz_e;

    function automatic logic [7:0] size_mask(input mem_sz_e sz);
        logic [7:0] m;
        unique case (sz)
            MEM_SZ_B: m = 8'h01;
            MEM_SZ_H: m = 8'h03;
            MEM_SZ_W: m = 8'h0F;
            default:  m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] size_trunc(input logic [63:0] d, input mem_sz_e sz);
        logic [63:0] t;
        unique case (sz)
            MEM_SZ_B: t = {56'd0, d[7:0]};
            MEM_SZ_H: t = {48'd0, d[15:0]};
            MEM_SZ_W: t = {32'd0, d[31:0]};
            default:  t = d;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/store_buffer_lane_fmt.sv
// Combinational store formatter: aligns data and byte mask to the 8-byte lane.
module store_lane_fmt
    import store_buffer_pkg::*;
#(
    parameter int unsigned AW = 64
) (
    input  logic [AW-1:0]           addr,
    input  logic [63:0]             data,
    input  logic [MEM_SZ_WIDTH-1:0] size,
    output logic [AW-1:0]           waddr,
    output logic [63:0]             wdata,
    output logic [7:0]              wmask,
    output logic                    misaligned
);

    mem_sz_e    sz;
    logic [2:0] sh;

    always_comb begin
        sz         = mem_sz_e'(size);
        sh         = addr[2:0];
        waddr      = {addr[AW-1:3], 3'b000};
        wdata      = size_trunc(data, sz) << {sh, 3'b000};
        wmask      = size_mask(sz) << sh;
        misaligned = 1'b0;
        unique case (sz)
            MEM_SZ_B: misaligned = 1'b0;
            MEM_SZ_H: misaligned = addr[0];
            MEM_SZ_W: misaligned = |addr[1:0];
            default:  misaligned = |addr[2:0];
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: formats execute-stage stores, queues them in a FIFO and drains
// them to the memory write port; flags loads that overlap a pending store.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = STB_DEPTH,
    parameter int unsigned AW    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [AW-1:0]           st_base,
    input  logic [AW-1:0]           st_offset,
    input  logic [63:0]             st_data,
    input  logic [MEM_SZ_WIDTH-1:0] st_size,
    output logic                    mem_wvalid,
    input  logic                    mem_wready,
    output logic [AW-1:0]           mem_waddr,
    output logic [63:0]             mem_wdata,
    output logic [7:0]              mem_wmask,
    input  logic [AW-1:0]           ld_addr,
    output logic                    ld_hit,
    output logic                    misalign_err,
    output logic [AW-1:0]           err_addr,
    output logic                    empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] waddr;
        logic [63:0]   wdata;
        logic [7:0]    wmask;
    } entry_t;

    entry_t        ent_q [DEPTH];
    entry_t        ent_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [AW-1:0] err_addr_q, err_addr_d;

    logic [AW-1:0] st_addr;
    logic [AW-1:0] fmt_waddr;
    logic [63:0]   fmt_wdata;
    logic [7:0]    fmt_wmask;
    logic          fmt_misaligned;
    logic          accept, push, pop;
    entry_t        head;
    logic          unused_ld_low;

    assign st_addr       = st_base + st_offset;
    assign unused_ld_low = ^ld_addr[2:0];

    store_lane_fmt #(.AW(AW)) u_fmt (
        .addr       (st_addr),
        .data       (st_data),
        .size       (st_size),
        .waddr      (fmt_waddr),
        .wdata      (fmt_wdata),
        .wmask      (fmt_wmask),
        .misaligned (fmt_misaligned)
    );

    always_comb begin
        empty      = (count_q == '0);
        st_ready   = (count_q < CW'(DEPTH));
        mem_wvalid = !empty;
        head       = ent_q[rd_ptr_q];
        mem_waddr  = mem_wvalid ? head.waddr : '0;
        mem_wdata  = mem_wvalid ? head.wdata : '0;
        mem_wmask  = mem_wvalid ? head.wmask : '0;

        accept = st_valid && st_ready;
        push   = accept && !fmt_misaligned;
        pop    = mem_wvalid && mem_wready;

        ent_d    = ent_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            ent_d[wr_ptr_q] = '{waddr: fmt_waddr, wdata: fmt_wdata, wmask: fmt_wmask};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        err_d      = accept && fmt_misaligned;
        err_addr_d = err_d ? st_addr : err_addr_q;

        // An entry is live when its distance from the read pointer is below count.
        ld_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(PW'(PW'(i) - rd_ptr_q)) < count_q) &&
                (ent_q[i].waddr[AW-1:3] == ld_addr[AW-1:3])) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign misalign_err = err_q;
    assign err_addr     = err_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            ent_q      <= ent_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule
